// File: rtl/ssh_pkg.sv
// Shared definitions for the SSH banner packet generator.
// Banner ROM contents, clamp limits and FSM state encoding.
package ssh_pkg;

    localparam logic [31:0] SSH_MAGIC = 32'h2d485353;
    localparam logic [7:0]  PROTO_TCP = 8'h06;

    localparam int BANNER_DEPTH = 4;
    localparam int MIN_BEATS_DEF = 2;
    localparam int MAX_BEATS_DEF = 32;

    // Little-endian ASCII: "SSH-2.0-", "OpenSSH_", "8.9p1 Ub", "untu\r\n\0\0"
    localparam logic [63:0] BANNER_ROM [BANNER_DEPTH] = '{
        {32'h2d302e32, SSH_MAGIC},
        64'h5f4853536e65704f,
        64'h6255203170392e38,
        64'h00000a0d75746e75
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

endpackage

// File: rtl/ssh_banner_rom.sv
// Banner word lookup: payload index -> 64-bit word.
// Indices at or beyond BANNER_BEATS read as zero.
module ssh_banner_rom
    import ssh_pkg::*;
#(
    parameter int BANNER_BEATS = 4
) (
    input  logic [4:0]  i_idx,
    output logic [63:0] o_word
);

    // Zero padding past the banner, ROM word otherwise
    always_comb begin
        o_word = '0;
        if ((int'(i_idx) < BANNER_BEATS) && (int'(i_idx) < BANNER_DEPTH)) begin
            o_word = BANNER_ROM[i_idx[1:0]];
        end
    end

endmodule

// File: rtl/ssh_pkt_gen.sv
// Synthetic SSH banner packet source with valid/ready output.
// Optional SSH_PKT_GEN_CORRUPT_EN adds i_corrupt to flip banner byte 0.
module ssh_pkt_gen
    import ssh_pkg::*;
#(
    parameter int BANNER_BEATS = 4,
    parameter int MIN_BEATS    = MIN_BEATS_DEF,
    parameter int MAX_BEATS    = MAX_BEATS_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_flow_id,
    input  logic [2:0]  i_pkt_num,
    input  logic [7:0]  i_protocol,
    input  logic [5:0]  i_beats,
    input  logic [63:0] i_hdr_word,
`ifdef SSH_PKT_GEN_CORRUPT_EN
    input  logic        i_corrupt,
`endif
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pkt_data_valid,
    output logic [63:0] o_pkt_data,
    output logic [7:0]  o_pkt_len,
    output logic [2:0]  o_pkt_num,
    output logic [7:0]  o_pkt_protocol,
    output logic [7:0]  o_flow_id,
    output logic [5:0]  o_pkt_cycle_cnt
);

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_valid;
    logic [63:0] r_data;
    logic [7:0]  r_len;
    logic [2:0]  r_num;
    logic [7:0]  r_proto;
    logic [7:0]  r_flow;
    logic [5:0]  r_cnt;
    logic [5:0]  r_last;
    logic        r_corrupt;

    logic [5:0]  w_beats;
    logic [5:0]  w_last;
    logic [7:0]  w_len;
    logic [63:0] w_rom;
    logic [63:0] w_beat1;
    logic        w_corrupt_in;

`ifdef SSH_PKT_GEN_CORRUPT_EN
    assign w_corrupt_in = i_corrupt;
`else
    assign w_corrupt_in = 1'b0;
`endif

    // Clamp requested beat count into the legal packet size range
    always_comb begin
        w_beats = i_beats;
        if (i_beats < 6'(MIN_BEATS)) begin
            w_beats = 6'(MIN_BEATS);
        end else if (i_beats > 6'(MAX_BEATS)) begin
            w_beats = 6'(MAX_BEATS);
        end
    end

    assign w_last = w_beats - 6'd1;
    assign w_len  = {w_last[4:0], 3'b000};

    // Current beat index selects the word for the next beat
    ssh_banner_rom #(
        .BANNER_BEATS(BANNER_BEATS)
    ) u_rom (
        .i_idx  (r_cnt[4:0]),
        .o_word (w_rom)
    );

    // First banner beat optionally gets its leading 'S' lowercased
    always_comb begin
        w_beat1 = w_rom;
        if (r_corrupt) begin
            w_beat1[7:0] = w_rom[7:0] ^ 8'h20;
        end
    end

    // Packet FSM; every output is a register updated here
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_len     <= '0;
            r_num     <= '0;
            r_proto   <= '0;
            r_flow    <= '0;
            r_cnt     <= '0;
            r_last    <= '0;
            r_corrupt <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state   <= HDR;
                        r_busy    <= 1'b1;
                        r_valid   <= 1'b1;
                        r_data    <= i_hdr_word;
                        r_len     <= w_len;
                        r_num     <= i_pkt_num;
                        r_proto   <= i_protocol;
                        r_flow    <= i_flow_id;
                        r_cnt     <= '0;
                        r_last    <= w_last;
                        r_corrupt <= w_corrupt_in;
                    end
                end
                HDR: begin
                    if (i_ready) begin
                        r_state <= PAY;
                        r_cnt   <= 6'd1;
                        r_data  <= w_beat1;
                    end
                end
                PAY: begin
                    if (i_ready) begin
                        if (r_cnt == r_last) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt  <= r_cnt + 6'd1;
                            r_data <= w_rom;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pkt_data_valid = r_valid;
    assign o_pkt_data       = r_data;
    assign o_pkt_len        = r_len;
    assign o_pkt_num        = r_num;
    assign o_pkt_protocol   = r_proto;
    assign o_flow_id        = r_flow;
    assign o_pkt_cycle_cnt  = r_cnt;

endmodule

// File: tb/tb_ssh_pkt_gen.sv
// Directed bench for ssh_pkt_gen.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ssh_pkt_gen;
    import ssh_pkg::*;

    localparam logic [63:0] ROM0 = 64'h2d302e322d485353;
    localparam logic [63:0] ROM1 = 64'h5f4853536e65704f;
    localparam logic [63:0] ROM2 = 64'h6255203170392e38;
    localparam logic [63:0] ROM3 = 64'h00000a0d75746e75;
    localparam logic [63:0] HDRA = 64'ha5a5_0000_1234_5678;
    localparam logic [63:0] HDRB = 64'h0123_4567_89ab_cdef;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  flow_id;
    logic [2:0]  pkt_num;
    logic [7:0]  protocol;
    logic [5:0]  beats;
    logic [63:0] hdr_word;
    logic        corrupt;
    logic        ready;
    logic        busy;
    logic        done;
    logic        valid;
    logic [63:0] data;
    logic [7:0]  len;
    logic [2:0]  num_o;
    logic [7:0]  proto_o;
    logic [7:0]  flow_o;
    logic [5:0]  cnt;

    int checks;
    int errors;
    int xfers;
    int x0;

    ssh_pkt_gen dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_flow_id        (flow_id),
        .i_pkt_num        (pkt_num),
        .i_protocol       (protocol),
        .i_beats          (beats),
        .i_hdr_word       (hdr_word),
`ifdef SSH_PKT_GEN_CORRUPT_EN
        .i_corrupt        (corrupt),
`endif
        .i_ready          (ready),
        .o_busy           (busy),
        .o_done           (done),
        .o_pkt_data_valid (valid),
        .o_pkt_data       (data),
        .o_pkt_len        (len),
        .o_pkt_num        (num_o),
        .o_pkt_protocol   (proto_o),
        .o_flow_id        (flow_o),
        .o_pkt_cycle_cnt  (cnt)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count handshaken beats
    always @(posedge clk) begin
        if (valid && ready) xfers <= xfers + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input int k, input logic [63:0] hdr);
        case (k)
            0: return hdr;
            1: return ROM0;
            2: return ROM1;
            3: return ROM2;
            4: return ROM3;
            default: return 64'h0;
        endcase
    endfunction

    // Check one presented beat, then move to the next falling edge
    task automatic beat(input string tag, input int k, input logic [63:0] hdr);
        chk({tag, "_valid"}, 64'(valid), 64'd1);
        chk({tag, "_cnt"}, 64'(cnt), 64'(k));
        chk({tag, "_data"}, data, exp_word(k, hdr));
        @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] f, input logic [5:0] b, input logic [63:0] h);
        start    = 1'b1;
        flow_id  = f;
        pkt_num  = 3'd1;
        protocol = PROTO_TCP;
        beats    = b;
        hdr_word = h;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_valid0"}, 64'(valid), 64'd0);
        chk({tag, "_busy0"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        xfers    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        flow_id  = 8'h0;
        pkt_num  = 3'd0;
        protocol = 8'h0;
        beats    = 6'd0;
        hdr_word = 64'h0;
        corrupt  = 1'b0;
        ready    = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_len", 64'(len), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: six-beat packet, ready always high
        x0 = xfers;
        cmd(8'h12, 6'd6, HDRA);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_len", 64'(len), 64'd40);
        chk("t1_flow", 64'(flow_o), 64'h12);
        chk("t1_proto", 64'(proto_o), 64'h06);
        chk("t1_num", 64'(num_o), 64'd1);
        for (int k = 0; k < 6; k++) beat("t1", k, HDRA);
        chk_done("t1");
        chk("t1_xfers", 64'(xfers - x0), 64'd6);

        // 2: back-pressure for three cycles on beat 2
        x0 = xfers;
        cmd(8'h12, 6'd6, HDRA);
        beat("t2", 0, HDRA);
        beat("t2", 1, HDRA);
        ready = 1'b0;
        beat("t2h", 2, HDRA);
        beat("t2h", 2, HDRA);
        beat("t2h", 2, HDRA);
        ready = 1'b1;
        for (int k = 2; k < 6; k++) beat("t2", k, HDRA);
        chk_done("t2");
        chk("t2_xfers", 64'(xfers - x0), 64'd6);

        // 3a: beats=1 clamps up to 2
        cmd(8'h21, 6'd1, HDRB);
        chk("t3a_len", 64'(len), 64'd8);
        beat("t3a", 0, HDRB);
        beat("t3a", 1, HDRB);
        chk_done("t3a");

        // 3b: beats=40 clamps down to 32
        x0 = xfers;
        cmd(8'h22, 6'd40, HDRB);
        chk("t3b_len", 64'(len), 64'd248);
        for (int k = 0; k < 32; k++) beat("t3b", k, HDRB);
        chk_done("t3b");
        chk("t3b_xfers", 64'(xfers - x0), 64'd32);

        // 4: start mid-packet ignored, start in done cycle accepted
        cmd(8'h12, 6'd6, HDRA);
        beat("t4", 0, HDRA);
        beat("t4", 1, HDRA);
        start   = 1'b1;
        flow_id = 8'h55;
        beat("t4", 2, HDRA);
        start = 1'b0;
        chk("t4_flow_hold", 64'(flow_o), 64'h12);
        for (int k = 3; k < 6; k++) beat("t4", k, HDRA);
        chk("t4_done", 64'(done), 64'd1);
        start    = 1'b1;
        flow_id  = 8'h77;
        beats    = 6'd2;
        hdr_word = HDRB;
        @(negedge clk);
        start = 1'b0;
        chk("t4_flow_new", 64'(flow_o), 64'h77);
        beat("t4n", 0, HDRB);
        beat("t4n", 1, HDRB);
        chk_done("t4n");

        // 5: asynchronous reset during beat 3
        cmd(8'h12, 6'd6, HDRA);
        for (int k = 0; k < 3; k++) beat("t5", k, HDRA);
        chk("t5_cnt3", 64'(cnt), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(valid), 64'd0);
        chk("t5_data", data, 64'd0);
        chk("t5_cnt", 64'(cnt), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_idle", 64'(valid), 64'd0);
        end

`ifdef SSH_PKT_GEN_CORRUPT_EN
        // 6: corrupted banner first byte
        corrupt = 1'b1;
        cmd(8'h12, 6'd3, HDRA);
        corrupt = 1'b0;
        beat("t6", 0, HDRA);
        chk("t6_lo", 64'(data[31:0]), 64'h2d485373);
        chk("t6_full", data, 64'h2d302e322d485373);
        @(negedge clk);
        beat("t6", 2, HDRA);
        chk_done("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
